// File: rtl/txfifo_arbiter.sv
// txfifo_arbiter: shares one TX FIFO write port among N_REQ packet sources.
// Round-robin, one whole packet per grant. A packet starts only when the FIFO
// has START_FREE free words; after that, beats are gated by txfifo_full alone.
// Optional macro TXARB_HEADER_EN: emit a header word {grant_id[3:0], 0...}
// ahead of each packet.
module txfifo_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 32,
  parameter int TX_FIFO_SIZE = 4096,
  parameter int START_FREE   = 16,
  localparam int LW          = $clog2(TX_FIFO_SIZE) + 1,
  localparam int GW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         txfifo_data,
  output logic                      txfifo_wr,
  input  logic                      txfifo_full,
  input  logic [LW-1:0]             txfifo_load,
  output logic [GW-1:0]             grant_id,
  output logic                      busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
`ifdef TXARB_HEADER_EN
  localparam logic [1:0] HDR  = 2'd2;
  localparam int HDR_WORDS    = 1;
`else
  localparam int HDR_WORDS    = 0;
`endif

  localparam logic [GW-1:0] LAST_ID  = GW'(N_REQ - 1);
  localparam logic [LW:0]   SIZE_W   = (LW+1)'(TX_FIFO_SIZE);
  localparam logic [LW:0]   THRESH_W = (LW+1)'(START_FREE + HDR_WORDS);

  logic [1:0]                     state;
  logic [GW-1:0]                  rr_ptr;
  logic [N_REQ-1:0][DATA_W-1:0]   slot;
  logic [LW:0]                    load_ext;
  logic [LW:0]                    free;
  logic                           free_ok;
  logic [GW-1:0]                  sel;
  logic                           sel_vld;
  logic                           beat_acc;

  // Per-requester payload view of the flat data bus.
  assign slot = req_data;

  // Free words at full width; an over-range load reads as no room at all.
  always_comb begin
    load_ext = {1'b0, txfifo_load};
    free     = (load_ext > SIZE_W) ? '0 : SIZE_W - load_ext;
    free_ok  = (free >= THRESH_W);
  end

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!sel_vld && req_valid[idx]) begin
        sel_vld = 1'b1;
        sel     = GW'(idx);
      end
    end
  end

  // Write port: only the granted source can move data, and never into a full FIFO.
  always_comb begin
    req_ready   = '0;
    txfifo_wr   = 1'b0;
    txfifo_data = '0;
    beat_acc    = 1'b0;
    case (state)
      XFER: begin
        req_ready[grant_id] = !txfifo_full;
        beat_acc            = req_valid[grant_id] & !txfifo_full;
        txfifo_wr           = beat_acc;
        if (beat_acc) txfifo_data = slot[grant_id];
      end
`ifdef TXARB_HEADER_EN
      HDR: begin
        txfifo_wr = !txfifo_full;
        if (!txfifo_full) txfifo_data = {4'(grant_id), {(DATA_W-4){1'b0}}};
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  // Grant/packet sequencer; rr_ptr moves only when a packet completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld && free_ok) begin
            grant_id <= sel;
`ifdef TXARB_HEADER_EN
            state    <= HDR;
`else
            state    <= XFER;
`endif
          end
        end
`ifdef TXARB_HEADER_EN
        HDR: begin
          if (!txfifo_full) state <= XFER;
        end
`endif
        XFER: begin
          if (beat_acc && req_last[grant_id]) begin
            rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
